// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared constants, state encoding and width helper for the motor PWM slice
package motor_pkg;

    localparam int MOTOR_CMD_W = 8;
    localparam int CNT_W       = 16;

    localparam int DEF_CLK_DIV         = 50;
    localparam int DEF_PERIOD_TICKS    = 20000;
    localparam int DEF_MIN_PULSE_TICKS = 1000;
    localparam int DEF_TICKS_PER_LSB   = 4;
    localparam int DEF_MAX_PULSE_TICKS = 2000;
    localparam int DEF_ARM_FRAMES      = 50;
    localparam int DEF_TIMEOUT_FRAMES  = 10;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2
    } motor_state_e;

    // Computed in 32 bits so cmd*lsb can never wrap before saturation.
    function automatic logic [CNT_W-1:0] calc_width(
        input logic [MOTOR_CMD_W-1:0] cmd,
        input int                     min_t,
        input int                     lsb,
        input int                     max_t
    );
        int w;
        w = min_t + int'(cmd) * lsb;
        if (w > max_t) begin
            w = max_t;
        end
        return CNT_W'(w);
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - prescaler and frame tick counter shared by every motor channel
module pwm_tick_gen
    import motor_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_tick,
    output logic             o_frame_start,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] r_count;
    logic             r_frame_start;
    logic             w_tick;
    logic             w_wrap;

    assign w_tick = (r_presc == CNT_W'(CLK_DIV - 1));
    assign w_wrap = w_tick && (r_count == CNT_W'(PERIOD_TICKS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc       <= '0;
            r_count       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            r_presc       <= w_tick ? '0 : r_presc + CNT_W'(1);
            if (w_tick) begin
                r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
            end
        end
    end

    assign o_tick        = w_tick;
    assign o_frame_start = r_frame_start;
    assign o_count       = r_count;

endmodule

// File: rtl/motor_pwm_generator.sv
// rtl/motor_pwm_generator.sv - per-motor ESC PWM with arming sequencer
// Optional command watchdog enabled by defining MOTOR_PWM_FAILSAFE_EN.
module motor_pwm_generator
    import motor_pkg::*;
#(
    parameter int CLK_DIV         = DEF_CLK_DIV,
    parameter int PERIOD_TICKS    = DEF_PERIOD_TICKS,
    parameter int MIN_PULSE_TICKS = DEF_MIN_PULSE_TICKS,
    parameter int TICKS_PER_LSB   = DEF_TICKS_PER_LSB,
    parameter int MAX_PULSE_TICKS = DEF_MAX_PULSE_TICKS,
    parameter int ARM_FRAMES      = DEF_ARM_FRAMES,
    parameter int TIMEOUT_FRAMES  = DEF_TIMEOUT_FRAMES
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_arm,
    input  logic [MOTOR_CMD_W-1:0] i_cmd,
    input  logic                   i_cmd_valid,
    output logic                   o_pwm_out,
    output logic                   o_frame_start,
    output logic                   o_armed,
    output logic                   o_failsafe
);

    localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_PULSE_TICKS);
    localparam int               ACNT_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;

    logic                   w_tick;
    logic                   w_frame_start;
    logic [CNT_W-1:0]       w_count;
    logic                   w_boundary;
    motor_state_e           r_state;
    motor_state_e           w_state_nxt;
    logic [ACNT_W-1:0]      r_arm_cnt;
    logic [ACNT_W-1:0]      w_arm_cnt_nxt;
    logic [MOTOR_CMD_W-1:0] r_shadow;
    logic [MOTOR_CMD_W-1:0] w_cmd_eff;
    logic [CNT_W-1:0]       r_width;
    logic [CNT_W-1:0]       w_width_eff;
    logic                   r_pwm;
    logic                   w_armed;
    logic                   w_fs_nxt;

    pwm_tick_gen #(
        .CLK_DIV      (CLK_DIV),
        .PERIOD_TICKS (PERIOD_TICKS)
    ) u_tick_gen (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_tick        (w_tick),
        .o_frame_start (w_frame_start),
        .o_count       (w_count)
    );

    assign w_boundary = w_tick && (w_count == CNT_W'(PERIOD_TICKS - 1));

    // A strobe landing on the boundary bypasses the shadow so it applies this frame.
    assign w_cmd_eff = i_cmd_valid ? i_cmd : r_shadow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_DISARMED;
            r_arm_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_arm_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_arm_cnt_nxt = r_arm_cnt;
        if (!i_arm) begin
            w_state_nxt   = ST_DISARMED;
            w_arm_cnt_nxt = '0;
        end else if (w_boundary) begin
            case (r_state)
                ST_DISARMED: begin
                    w_state_nxt   = ST_ARMING;
                    w_arm_cnt_nxt = '0;
                end
                ST_ARMING: begin
                    if (r_arm_cnt == ACNT_W'(ARM_FRAMES - 1)) begin
                        w_state_nxt   = ST_ARMED;
                        w_arm_cnt_nxt = '0;
                    end else begin
                        w_arm_cnt_nxt = r_arm_cnt + ACNT_W'(1);
                    end
                end
                ST_ARMED: begin
                    w_state_nxt = ST_ARMED;
                end
                default: begin
                    w_state_nxt   = ST_DISARMED;
                    w_arm_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_armed = 1'b0;
        if (r_state == ST_ARMED) begin
            w_armed = 1'b1;
        end
    end

`ifdef MOTOR_PWM_FAILSAFE_EN
    localparam int TCNT_W = $clog2(TIMEOUT_FRAMES + 1);

    logic [TCNT_W-1:0] r_to_cnt;
    logic              r_failsafe;

    assign w_fs_nxt = !i_cmd_valid &&
                      (r_failsafe || (w_boundary && (r_to_cnt == TCNT_W'(TIMEOUT_FRAMES - 1))));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt   <= '0;
            r_failsafe <= 1'b0;
        end else begin
            r_failsafe <= w_fs_nxt;
            if (i_cmd_valid) begin
                r_to_cnt <= '0;
            end else if (w_boundary && (r_to_cnt != TCNT_W'(TIMEOUT_FRAMES))) begin
                r_to_cnt <= r_to_cnt + TCNT_W'(1);
            end
        end
    end

    assign o_failsafe = r_failsafe;
`else
    assign w_fs_nxt   = 1'b0;
    assign o_failsafe = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
            r_width  <= MIN_W;
        end else begin
            if (i_cmd_valid) begin
                r_shadow <= i_cmd;
            end
            if (!i_arm) begin
                r_width <= MIN_W;
            end else if (w_boundary) begin
                r_width <= ((r_state == ST_ARMED) && !w_fs_nxt)
                         ? calc_width(w_cmd_eff, MIN_PULSE_TICKS, TICKS_PER_LSB, MAX_PULSE_TICKS)
                         : MIN_W;
            end
        end
    end

    // Disarm truncates the running pulse without waiting for the width register.
    assign w_width_eff = i_arm ? r_width : MIN_W;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (w_count < w_width_eff);
        end
    end

    assign o_pwm_out     = r_pwm;
    assign o_frame_start = w_frame_start;
    assign o_armed       = w_armed;

endmodule
